commit_regfile: RTL and testbench
=================================

# commit_regfile

Architectural register file and retire point at the consumer end of the dual-issue commit pipeline register. Takes the two registered commit lanes (instruction word, rd, pc, write data, regwrite) and writes up to two results per cycle into 31 general registers (x0 hardwired zero). Serves four combinational read ports for the two instructions in decode/issue, with same-cycle write bypass. Also keeps a 64-bit retired-instruction counter and the PC of the youngest retired instruction.

## Interface
- No parameters; XLEN fixed at 32, 32 architectural registers.
- clk  in  1  single clock; all state updates on rising edge
- rstn  in  1  reset, synchronous, active-low
- commit_in_instr1 / commit_in_instr2  in  32  committed instruction words; 32'h0 marks a bubble
- commit_in_instr1_rd_address / commit_in_instr2_rd_address  in  5  destination register
- commit_in_instr1_pc / commit_in_instr2_pc  in  32  PC of each committed instruction
- commit_in_instr1_write_data / commit_in_instr2_write_data  in  32  result to write
- commit_in_instr1_regwrite / commit_in_instr2_regwrite  in  1  write enable per lane
- rd_instr1_rs1_address, rd_instr1_rs2_address, rd_instr2_rs1_address, rd_instr2_rs2_address  in  5  read addresses
- rd_instr1_rs1_data, rd_instr1_rs2_data, rd_instr2_rs1_data, rd_instr2_rs2_data  out  32  read data (combinational)
- instret  out  64  count of retired (non-bubble) instructions
- last_commit_pc  out  32  PC of youngest instruction retired in the most recent non-empty commit cycle

## Operation
- Lane 1 is older than lane 2 in program order.
- Lane n writes when regwrite_n=1 and rd_n!=0; writes with rd=0 are dropped.
- Both lanes writing the same rd in one cycle: lane 2 data is stored (younger wins).
- Lane retires when its instruction word !=32'h0, independent of regwrite (stores, branches retire without writing).
- instret += number of retiring lanes (0, 1 or 2) per cycle; 64-bit, wraps from 2^64-1 to 0 (adding 2 to 2^64-1 gives 1).
- last_commit_pc: lane 2 pc if lane 2 retires, else lane 1 pc if lane 1 retires, else hold.
- Read port, in priority order: address 0 -> 0; matches lane 2 active write -> lane 2 write_data; matches lane 1 active write -> lane 1 write_data; else array contents.
- "Active write" = regwrite=1 and rd!=0 (same qualification as the array write).
- Read ports are independent; any number may address the same register.

## Timing
- Reset: on rising clk with rstn=0, all 31 registers <= 0, instret <= 0, last_commit_pc <= 0; commit inputs ignored that cycle. Read data after reset = 0 for all addresses (bypass still applies combinationally to current commit inputs).
- Reset asserted mid-stream: writes and retires presented in the reset cycle are lost; no partial update.
- Write latency: value enters array at the rising edge ending the commit cycle; visible through bypass in the commit cycle itself, through array from the next cycle. Net read-after-write latency 0 cycles.
- instret and last_commit_pc registered; updated at the edge ending the commit cycle, visible next cycle.
- Read path purely combinational from addresses and commit inputs; no clock-to-read latency.
- No backpressure; one commit pair accepted every cycle.

## Test plan
- Reset: drive rstn=0 one edge after writing x5=32'hDEAD_BEEF -> all four read ports on x5 return 0, instret=0, last_commit_pc=0.
- Dual write: lane1 x3<=32'h11, lane2 x4<=32'h22, both instr nonzero, pc 32'h100/32'h104 -> same cycle bypass reads 0x11/0x22; next cycle array reads same; instret=2, last_commit_pc=32'h104.
- Same-rd conflict: lane1 x7<=32'hAAAA, lane2 x7<=32'hBBBB -> same-cycle read of x7 = 0xBBBB, next cycle 0xBBBB.
- x0 and disabled writes: lane1 rd=0 data 32'hFFFF regwrite=1, lane2 rd=9 regwrite=0 -> x0 reads 0, x9 unchanged, both retire (instret +2).
- Bubbles: lane1 instr=0 with pc 32'h200, lane2 instr=32'h13 pc 32'h204 -> instret +1, last_commit_pc=32'h204; next cycle both bubbles -> instret and last_commit_pc hold.
- Counter wrap: preload instret to 64'hFFFF_FFFF_FFFF_FFFF via retirement (or force), retire two -> instret=1.

Source files
------------

// File: rtl/commit_regfile.sv
// Architectural register file and retire point for the dual-issue commit stage.
// Two commit lanes write into x1..x31; four combinational read ports bypass same-cycle writes.

module commit_regfile_rdport (
  input  logic [4:0]        addr,
  input  logic [31:1][31:0] regs,
  input  logic [1:0]        wr_en,
  input  logic [1:0][4:0]   wr_rd,
  input  logic [1:0][31:0]  wr_data,
  output logic [31:0]       data
);
  // Lane index 1 is the younger instruction, so its write is checked first.
  always_comb begin
    data = '0;
    if (addr == 5'd0)
      data = '0;
    else if (wr_en[1] && wr_rd[1] == addr)
      data = wr_data[1];
    else if (wr_en[0] && wr_rd[0] == addr)
      data = wr_data[0];
    else
      data = regs[addr];
  end
endmodule

module commit_regfile (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] commit_in_instr1,
  input  logic [31:0] commit_in_instr2,
  input  logic [4:0]  commit_in_instr1_rd_address,
  input  logic [4:0]  commit_in_instr2_rd_address,
  input  logic [31:0] commit_in_instr1_pc,
  input  logic [31:0] commit_in_instr2_pc,
  input  logic [31:0] commit_in_instr1_write_data,
  input  logic [31:0] commit_in_instr2_write_data,
  input  logic        commit_in_instr1_regwrite,
  input  logic        commit_in_instr2_regwrite,
  input  logic [4:0]  rd_instr1_rs1_address,
  input  logic [4:0]  rd_instr1_rs2_address,
  input  logic [4:0]  rd_instr2_rs1_address,
  input  logic [4:0]  rd_instr2_rs2_address,
  output logic [31:0] rd_instr1_rs1_data,
  output logic [31:0] rd_instr1_rs2_data,
  output logic [31:0] rd_instr2_rs1_data,
  output logic [31:0] rd_instr2_rs2_data,
  output logic [63:0] instret,
  output logic [31:0] last_commit_pc
);
  localparam int NUM_LANES = 2;
  localparam int NUM_RD    = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] data;
    logic        we;
  } commit_t;

  commit_t [NUM_LANES-1:0]        lane;
  logic    [NUM_LANES-1:0]        wr_en;
  logic    [NUM_LANES-1:0]        retire;
  logic    [NUM_LANES-1:0][4:0]   wr_rd;
  logic    [NUM_LANES-1:0][31:0]  wr_data;
  logic    [31:1][31:0]           regs;
  logic    [63:0]                 instret_q;
  logic    [31:0]                 last_pc_q;
  logic    [1:0]                  retire_cnt;

  assign lane[0] = '{instr: commit_in_instr1, rd: commit_in_instr1_rd_address,
                     pc: commit_in_instr1_pc, data: commit_in_instr1_write_data,
                     we: commit_in_instr1_regwrite};
  assign lane[1] = '{instr: commit_in_instr2, rd: commit_in_instr2_rd_address,
                     pc: commit_in_instr2_pc, data: commit_in_instr2_write_data,
                     we: commit_in_instr2_regwrite};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign wr_en[l]   = lane[l].we && (lane[l].rd != 5'd0);
    assign retire[l]  = (lane[l].instr != 32'h0);
    assign wr_rd[l]   = lane[l].rd;
    assign wr_data[l] = lane[l].data;
  end

  // Younger lane wins when both target the same register.
  for (genvar r = 1; r < 32; r++) begin : g_reg
    always_ff @(posedge clk) begin
      if (!rstn)
        regs[r] <= '0;
      else if (wr_en[1] && wr_rd[1] == 5'(r))
        regs[r] <= wr_data[1];
      else if (wr_en[0] && wr_rd[0] == 5'(r))
        regs[r] <= wr_data[0];
    end
  end

  assign retire_cnt = {1'b0, retire[0]} + {1'b0, retire[1]};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      instret_q <= '0;
      last_pc_q <= '0;
    end else begin
      instret_q <= instret_q + 64'(retire_cnt);
      if (retire[1])
        last_pc_q <= lane[1].pc;
      else if (retire[0])
        last_pc_q <= lane[0].pc;
    end
  end

  assign instret        = instret_q;
  assign last_commit_pc = last_pc_q;

  logic [NUM_RD-1:0][4:0]  rd_addr;
  logic [NUM_RD-1:0][31:0] rd_data;

  assign rd_addr = {rd_instr2_rs2_address, rd_instr2_rs1_address,
                    rd_instr1_rs2_address, rd_instr1_rs1_address};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    commit_regfile_rdport u_port (
      .addr    (rd_addr[p]),
      .regs    (regs),
      .wr_en   (wr_en),
      .wr_rd   (wr_rd),
      .wr_data (wr_data),
      .data    (rd_data[p])
    );
  end

  assign rd_instr1_rs1_data = rd_data[0];
  assign rd_instr1_rs2_data = rd_data[1];
  assign rd_instr2_rs1_data = rd_data[2];
  assign rd_instr2_rs2_data = rd_data[3];
endmodule

// File: tb/tb_commit_regfile.sv
// Directed bench for commit_regfile: reset, bypass, write conflicts, retire counting, wrap.

module tb_commit_regfile;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] i1, i2, pc1, pc2, d1, d2;
  logic [4:0]  rd1, rd2;
  logic        we1, we2;
  logic [4:0]  a0, a1, a2, a3;
  logic [31:0] q0, q1, q2, q3;
  logic [63:0] instret;
  logic [31:0] lpc;
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  commit_regfile dut (
    .clk(clk), .rstn(rstn),
    .commit_in_instr1(i1), .commit_in_instr2(i2),
    .commit_in_instr1_rd_address(rd1), .commit_in_instr2_rd_address(rd2),
    .commit_in_instr1_pc(pc1), .commit_in_instr2_pc(pc2),
    .commit_in_instr1_write_data(d1), .commit_in_instr2_write_data(d2),
    .commit_in_instr1_regwrite(we1), .commit_in_instr2_regwrite(we2),
    .rd_instr1_rs1_address(a0), .rd_instr1_rs2_address(a1),
    .rd_instr2_rs1_address(a2), .rd_instr2_rs2_address(a3),
    .rd_instr1_rs1_data(q0), .rd_instr1_rs2_data(q1),
    .rd_instr2_rs1_data(q2), .rd_instr2_rs2_data(q3),
    .instret(instret), .last_commit_pc(lpc)
  );

  task automatic set_lane1(input logic [31:0] ins, input logic [4:0] rd,
                           input logic [31:0] pc, input logic [31:0] d, input logic we);
    i1 = ins; rd1 = rd; pc1 = pc; d1 = d; we1 = we;
  endtask

  task automatic set_lane2(input logic [31:0] ins, input logic [4:0] rd,
                           input logic [31:0] pc, input logic [31:0] d, input logic we);
    i2 = ins; rd2 = rd; pc2 = pc; d2 = d; we2 = we;
  endtask

  task automatic idle();
    set_lane1(32'h0, 5'd0, 32'h0, 32'h0, 1'b0);
    set_lane2(32'h0, 5'd0, 32'h0, 32'h0, 1'b0);
  endtask

  // Drive at negedge, settle 1 time unit before comparing.
  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; idle(); a0 = 5; a1 = 5; a2 = 5; a3 = 5;
    step(); step();
    rstn = 1'b1;
    set_lane1(32'h13, 5'd5, 32'h50, 32'hDEAD_BEEF, 1'b1);
    step();
    idle();
    #1;
    total++; if (q0 !== 32'hDEAD_BEEF) $display("FAIL reset_prewrite x5 got %h exp %h", q0, 32'hDEAD_BEEF); else passed++;
    rstn = 1'b0;
    set_lane1(32'h13, 5'd6, 32'h60, 32'h6666, 1'b1);
    set_lane2(32'h13, 5'd5, 32'h64, 32'h5555, 1'b1);
    step();
    rstn = 1'b1; idle(); #1;
    total++; if (q0 !== 32'h0) $display("FAIL reset_rp0 got %h exp 0", q0); else passed++;
    total++; if (q1 !== 32'h0) $display("FAIL reset_rp1 got %h exp 0", q1); else passed++;
    total++; if (q2 !== 32'h0) $display("FAIL reset_rp2 got %h exp 0", q2); else passed++;
    total++; if (q3 !== 32'h0) $display("FAIL reset_rp3 got %h exp 0", q3); else passed++;
    total++; if (instret !== 64'd0) $display("FAIL reset_instret got %0d exp 0", instret); else passed++;
    total++; if (lpc !== 32'h0) $display("FAIL reset_lpc got %h exp 0", lpc); else passed++;
    a0 = 6; #1;
    total++; if (q0 !== 32'h0) $display("FAIL reset_lost_write x6 got %h exp 0", q0); else passed++;
  endtask

  task automatic test_dual_write();
    set_lane1(32'h13, 5'd3, 32'h100, 32'h11, 1'b1);
    set_lane2(32'h33, 5'd4, 32'h104, 32'h22, 1'b1);
    a0 = 3; a1 = 4; a2 = 4; a3 = 3; #1;
    total++; if (q0 !== 32'h11) $display("FAIL dual_bypass_x3 got %h exp 11", q0); else passed++;
    total++; if (q1 !== 32'h22) $display("FAIL dual_bypass_x4 got %h exp 22", q1); else passed++;
    step();
    idle(); #1;
    total++; if (q3 !== 32'h11) $display("FAIL dual_array_x3 got %h exp 11", q3); else passed++;
    total++; if (q2 !== 32'h22) $display("FAIL dual_array_x4 got %h exp 22", q2); else passed++;
    total++; if (instret !== 64'd2) $display("FAIL dual_instret got %0d exp 2", instret); else passed++;
    total++; if (lpc !== 32'h104) $display("FAIL dual_lpc got %h exp 104", lpc); else passed++;
  endtask

  task automatic test_same_rd();
    set_lane1(32'h13, 5'd7, 32'h110, 32'hAAAA, 1'b1);
    set_lane2(32'h13, 5'd7, 32'h114, 32'hBBBB, 1'b1);
    a0 = 7; a1 = 7; a2 = 7; a3 = 7; #1;
    total++; if (q0 !== 32'hBBBB) $display("FAIL same_rd_bypass got %h exp bbbb", q0); else passed++;
    total++; if (q3 !== 32'hBBBB) $display("FAIL same_rd_bypass_p3 got %h exp bbbb", q3); else passed++;
    step();
    idle(); #1;
    total++; if (q1 !== 32'hBBBB) $display("FAIL same_rd_array got %h exp bbbb", q1); else passed++;
    total++; if (instret !== 64'd4) $display("FAIL same_rd_instret got %0d exp 4", instret); else passed++;
  endtask

  task automatic test_x0_disabled();
    set_lane1(32'h13, 5'd9, 32'h120, 32'h99, 1'b1);
    step();
    set_lane1(32'h13, 5'd0, 32'h124, 32'hFFFF, 1'b1);
    set_lane2(32'h23, 5'd9, 32'h128, 32'h1234, 1'b0);
    a0 = 0; a1 = 9; a2 = 3; a3 = 4; #1;
    total++; if (q0 !== 32'h0) $display("FAIL x0_bypass got %h exp 0", q0); else passed++;
    total++; if (q1 !== 32'h99) $display("FAIL disabled_bypass_x9 got %h exp 99", q1); else passed++;
    total++; if (q2 !== 32'h11) $display("FAIL unrelated_x3 got %h exp 11", q2); else passed++;
    step();
    idle(); #1;
    total++; if (q0 !== 32'h0) $display("FAIL x0_array got %h exp 0", q0); else passed++;
    total++; if (q1 !== 32'h99) $display("FAIL disabled_array_x9 got %h exp 99", q1); else passed++;
    total++; if (instret !== 64'd7) $display("FAIL x0_instret got %0d exp 7", instret); else passed++;
    total++; if (lpc !== 32'h128) $display("FAIL x0_lpc got %h exp 128", lpc); else passed++;
  endtask

  task automatic test_bubbles();
    set_lane1(32'h0, 5'd10, 32'h200, 32'h77, 1'b0);
    set_lane2(32'h13, 5'd11, 32'h204, 32'h88, 1'b1);
    a0 = 11; #1;
    total++; if (q0 !== 32'h88) $display("FAIL bubble_bypass_x11 got %h exp 88", q0); else passed++;
    step();
    total++; if (instret !== 64'd8) $display("FAIL bubble_instret got %0d exp 8", instret); else passed++;
    total++; if (lpc !== 32'h204) $display("FAIL bubble_lpc got %h exp 204", lpc); else passed++;
    set_lane1(32'h0, 5'd0, 32'h300, 32'h0, 1'b0);
    set_lane2(32'h0, 5'd0, 32'h304, 32'h0, 1'b0);
    step();
    total++; if (instret !== 64'd8) $display("FAIL bubble_hold_instret got %0d exp 8", instret); else passed++;
    total++; if (lpc !== 32'h204) $display("FAIL bubble_hold_lpc got %h exp 204", lpc); else passed++;
    set_lane1(32'h13, 5'd0, 32'h400, 32'h0, 1'b0);
    set_lane2(32'h0, 5'd0, 32'h404, 32'h0, 1'b0);
    step();
    idle(); #1;
    total++; if (lpc !== 32'h400) $display("FAIL lane1_only_lpc got %h exp 400", lpc); else passed++;
    total++; if (instret !== 64'd9) $display("FAIL lane1_only_instret got %0d exp 9", instret); else passed++;
  endtask

  task automatic test_wrap();
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    #1;
    total++; if (instret !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL wrap_preload got %h", instret); else passed++;
    set_lane1(32'h13, 5'd0, 32'h500, 32'h0, 1'b0);
    set_lane2(32'h13, 5'd0, 32'h504, 32'h0, 1'b0);
    step();
    idle(); #1;
    total++; if (instret !== 64'd1) $display("FAIL wrap_instret got %0d exp 1", instret); else passed++;
    total++; if (lpc !== 32'h504) $display("FAIL wrap_lpc got %h exp 504", lpc); else passed++;
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_same_rd();
    test_x0_disabled();
    test_bubbles();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
